risc5_mem_ctrl: RTL and testbench
=================================

// Module: risc5_mem_ctrl
// PURPOSE
//  Memory/bus controller directly downstream of the RISC5 CPU. Each cycle it takes the CPU's
//  byte address and rd/wr/ben strobes, and serves one of three targets: external 32-bit
//  async SRAM, the I/O window or the boot-ROM window. It returns fetch data on codebus and
//  load data on inbus, and asserts memwait to freeze the CPU while SRAM wait states elapse.
// PARAMETERS
//  WAIT_CYCLES  2   stall cycles per SRAM read; writes stall max(WAIT_CYCLES,1)
//  ADR_W        24  CPU byte-address width
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  cpu_adr      in   24  byte address (fetch or data)
//  cpu_rd       in   1   data load
//  cpu_wr       in   1   data store
//  cpu_ben      in   1   byte access
//  cpu_wdata    in   32  store data, byte already replicated to its lane
//  memwait      out  1   1 = CPU holds all state this cycle
//  inbus        out  32  load data
//  codebus      out  32  instruction word
//  sram_a       out  22  word address = cpu_adr[23:2]
//  sram_din     in   32  SRAM read data
//  sram_dout    out  32  SRAM write data = cpu_wdata
//  sram_ce_n    out  1   chip enable
//  sram_oe_n    out  1   output enable
//  sram_we_n    out  1   write enable
//  sram_be_n    out  4   lane enables
//  io_adr       out  4   cpu_adr[5:2]
//  io_rd        out  1   I/O read strobe
//  io_wr        out  1   I/O write strobe
//  io_rdata     in   32  I/O read data
// BEHAVIOUR
//  Decode (combinational): fetch = ~cpu_rd&~cpu_wr; io_sel = cpu_adr[23:6]=='1 (data only);
//   rom_sel = fetch & cpu_adr[23:14]=='1; otherwise the access targets SRAM.
//  ROM fetch: no SRAM cycle, memwait=0, codebus=don't care (CPU uses its PROM).
//  I/O: zero wait. io_rd=cpu_rd&io_sel, io_wr=cpu_wr&io_sel; inbus=io_rdata; strobes last 1 cycle.
//  SRAM FSM, states IDLE/WAIT, counter cnt[$clog2(WAIT_CYCLES+2)-1:0]:
//   IDLE, SRAM access, N=needed stalls>0: memwait=1, cnt<=1, ->WAIT. N=0: complete now, stay IDLE.
//   WAIT: cnt<N -> memwait=1, cnt++. cnt==N -> memwait=0 (completion cycle), ->IDLE, cnt<=0.
//   cpu_adr/strobes are stable while memwait=1; the controller does not re-latch them.
//  Completion cycle: codebus=sram_din (fetch) / inbus=sram_din (load), combinational, so CPU captures.
//  Back-to-back accesses each pay full wait, incl. repeated fetch of same PC during mul/div stalls.
//  SRAM strobes: ce_n=0, oe_n=~(read) during every cycle of an SRAM access; else all 1.
//   Write: we_n=0 in all cycles except the completion cycle (address/data hold); be_n=0000 unless
//   cpu_ben, then only lane cpu_adr[1:0] low. Reads always be_n=0000.
//  Reset (async, anytime incl. mid-access): state=IDLE, cnt=0, memwait=0, all *_n=1,
//   io_rd=io_wr=0; aborted write may leave one SRAM word undefined.
//  cpu_rd&cpu_wr together is illegal; treated as write.
// CONFIGURATION
//  RISC5_MEM_FETCH_BUF_EN defined: one-entry fetch buffer (valid, 22-bit tag, 32-bit data).
//   Loaded on every completed SRAM fetch. A fetch hitting valid tag: codebus=buffer,
//   memwait=0, no SRAM strobes. Cleared by reset and by an SRAM write to the tagged word.
//  Undefined: every SRAM fetch pays WAIT_CYCLES; no buffer registers exist.
// STRUCTURE
//  Package risc5_mem_pkg: state encoding (IDLE, WAIT), IO_TOP_MASK, ROM_TOP_MASK,
//   BE decode function.
//  Sub-module risc5_fetch_buf (tag compare, capture, invalidate), instantiated only under the macro.
// TESTING
//  Fetch 0x000100, WAIT_CYCLES=2, sram_din=0xA0000005 -> memwait 1,1,0; codebus valid
//   3rd cycle; oe_n=0 all 3.
//  SB r,0x000203 with data 0x000000AA -> we_n 0,0,1; be_n=0111; sram_a=0x000080.
//  LDR from 0xFFFFC4, io_rdata=0x12345678 -> memwait=0; io_rd 1 cycle;
//   io_adr=1; inbus=0x12345678.
//  Fetch 0xFFE000 -> no SRAM strobes, memwait=0.
//  Assert rst in WAIT (cnt=1) -> memwait, we_n, oe_n, ce_n deassert same cycle;
//   state IDLE after release.
//  With RISC5_MEM_FETCH_BUF_EN, fetch 0x000100 twice -> 2nd has memwait=0. After SW to 0x000100,
//   the next fetch of 0x000100 stalls again.

Source files
------------

// File: rtl/risc5_mem_pkg.sv
// Shared definitions for the RISC5 memory controller: FSM encoding, window masks, lane decode.
package risc5_mem_pkg;

    // SRAM access FSM encoding
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    // Upper address bits that select the I/O window (data) and boot-ROM window (fetch)
    localparam logic [17:0] IO_TOP_MASK  = 18'h3FFFF;
    localparam logic [9:0]  ROM_TOP_MASK = 10'h3FF;

    // Active-low SRAM lane enables: all lanes for word access, one lane for byte access
    function automatic logic [3:0] be_n_decode(input logic ben, input logic [1:0] lane);
        logic [3:0] be_n;
        be_n = 4'h0;
        if (ben) begin
            be_n = ~(4'b0001 << lane);
        end
        return be_n;
    endfunction

endpackage

// File: rtl/risc5_mem_ctrl_if.sv
// Bus bundle between the RISC5 CPU, external SRAM, I/O window and the memory controller.
// master: everything outside the controller (CPU, SRAM, I/O). slave: the controller.
interface risc5_mem_ctrl_if #(
    parameter int unsigned ADR_W = 24
);
    logic [ADR_W-1:0] cpu_adr;
    logic             cpu_rd;
    logic             cpu_wr;
    logic             cpu_ben;
    logic [31:0]      cpu_wdata;
    logic             memwait;
    logic [31:0]      inbus;
    logic [31:0]      codebus;
    logic [ADR_W-3:0] sram_a;
    logic [31:0]      sram_din;
    logic [31:0]      sram_dout;
    logic             sram_ce_n;
    logic             sram_oe_n;
    logic             sram_we_n;
    logic [3:0]       sram_be_n;
    logic [3:0]       io_adr;
    logic             io_rd;
    logic             io_wr;
    logic [31:0]      io_rdata;

    modport master (
        output cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata, sram_din, io_rdata,
        input  memwait, inbus, codebus, sram_a, sram_dout, sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_be_n, io_adr, io_rd, io_wr
    );

    modport slave (
        input  cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata, sram_din, io_rdata,
        output memwait, inbus, codebus, sram_a, sram_dout, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_be_n, io_adr, io_rd, io_wr
    );

endinterface

// File: rtl/risc5_fetch_buf.sv
// One-entry instruction fetch buffer: filled by completed SRAM fetches, dropped on a write
// to the buffered word. Only instantiated when RISC5_MEM_FETCH_BUF_EN is defined.
module risc5_fetch_buf #(
    parameter int unsigned TagW = 22
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            lookup_i,
    input  logic            fill_i,
    input  logic            inval_i,
    input  logic [TagW-1:0] tag_i,
    input  logic [31:0]     data_i,
    output logic            hit_o,
    output logic [31:0]     data_o
);

    logic            valid_d, valid_q;
    logic [TagW-1:0] tag_d, tag_q;
    logic [31:0]     data_d, data_q;

    // Capture on fill; a store to the tagged word invalidates the entry
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = tag_i;
            data_d  = data_i;
        end else if (inval_i && (tag_i == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    // Hit when a fetch matches the valid tag
    always_comb begin
        hit_o  = lookup_i & valid_q & (tag_i == tag_q);
        data_o = data_q;
    end

endmodule

// File: rtl/risc5_mem_ctrl.sv
// RISC5 memory/bus controller: decodes each CPU access to SRAM, I/O or boot ROM, sequences
// SRAM wait states with memwait, and returns fetch/load data combinationally.
// Optional feature macro: RISC5_MEM_FETCH_BUF_EN (one-entry fetch buffer).
module risc5_mem_ctrl
    import risc5_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADR_W       = 24
) (
    input  logic              clk,
    input  logic              rst,
    risc5_mem_ctrl_if.slave   bus
);

    localparam int unsigned CNT_W   = $clog2(WAIT_CYCLES + 2);
    localparam int unsigned WR_WAIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES : 1;
    localparam logic [CNT_W-1:0] NeedRd = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] NeedWr = CNT_W'(WR_WAIT);

    logic             fetch, is_wr, is_rd, io_sel, rom_sel, sram_acc, done;
    logic             buf_hit;
    logic [31:0]      buf_data;
    logic [CNT_W-1:0] need;
    logic [0:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Target decode; reset suppresses any SRAM cycle so strobes drop immediately
    always_comb begin
        fetch    = ~bus.cpu_rd & ~bus.cpu_wr;
        is_wr    = bus.cpu_wr;
        is_rd    = bus.cpu_rd & ~bus.cpu_wr;
        io_sel   = ~fetch & (bus.cpu_adr[ADR_W-1:6] == IO_TOP_MASK);
        rom_sel  = fetch & (bus.cpu_adr[ADR_W-1:14] == ROM_TOP_MASK);
        sram_acc = ~rst & ~io_sel & ~rom_sel & ~buf_hit;
        need     = is_wr ? NeedWr : NeedRd;
    end

`ifdef RISC5_MEM_FETCH_BUF_EN
    risc5_fetch_buf #(
        .TagW (ADR_W - 2)
    ) u_fetch_buf (
        .clk_i    (clk),
        .rst_i    (rst),
        .lookup_i (fetch & ~rom_sel & ~rst),
        .fill_i   (sram_acc & fetch & done),
        .inval_i  (sram_acc & is_wr),
        .tag_i    (bus.cpu_adr[ADR_W-1:2]),
        .data_i   (bus.sram_din),
        .hit_o    (buf_hit),
        .data_o   (buf_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = 32'h0;
`endif

    // Wait-state sequencing: cnt counts stalls already spent; done marks the completion cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (!sram_acc) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (state_q == StIdle) begin
            if (need == '0) begin
                done = 1'b1;
            end else begin
                state_d = StWait;
                cnt_d   = CNT_W'(1);
            end
        end else if (cnt_q < need) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            done    = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    // FSM state and stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus outputs; write strobe released in the completion cycle so address/data hold
    always_comb begin
        bus.memwait   = sram_acc & ~done;
        bus.sram_a    = bus.cpu_adr[ADR_W-1:2];
        bus.sram_dout = bus.cpu_wdata;
        bus.sram_ce_n = ~sram_acc;
        bus.sram_oe_n = ~(sram_acc & ~is_wr);
        bus.sram_we_n = ~(sram_acc & is_wr & ~done);
        bus.sram_be_n = 4'hF;
        if (sram_acc) begin
            bus.sram_be_n = is_wr ? be_n_decode(bus.cpu_ben, bus.cpu_adr[1:0]) : 4'h0;
        end
        bus.io_adr  = bus.cpu_adr[5:2];
        bus.io_rd   = ~rst & is_rd & io_sel;
        bus.io_wr   = ~rst & is_wr & io_sel;
        bus.inbus   = io_sel ? bus.io_rdata : bus.sram_din;
        bus.codebus = buf_hit ? buf_data : bus.sram_din;
    end

endmodule

// File: tb/tb_risc5_mem_ctrl.sv
// Directed bench for risc5_mem_ctrl with WAIT_CYCLES=2. Expected values are hand-derived.
module tb_risc5_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    risc5_mem_ctrl_if #(.ADR_W(24)) bus ();

    risc5_mem_ctrl #(
        .WAIT_CYCLES (2),
        .ADR_W       (24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [23:0] adr, input logic rd, input logic wr,
                         input logic ben, input logic [31:0] wdata);
        bus.cpu_adr   = adr;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_ben   = ben;
        bus.cpu_wdata = wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Idle CPU: fetch from the boot-ROM window, which never touches SRAM
    task automatic drive_idle();
        drive(24'hFFE000, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Walk one SRAM access of `stalls` stall cycles plus its completion cycle
    task automatic run_sram(input string tag, input int stalls, input logic wr,
                            input logic [3:0] be_exp, input logic [31:0] data_exp,
                            input logic is_fetch);
        for (int i = 0; i <= stalls; i++) begin
            @(negedge clk);
            check_val({tag, ".memwait"}, 32'(bus.memwait), (i < stalls) ? 32'd1 : 32'd0);
            check_val({tag, ".ce_n"}, 32'(bus.sram_ce_n), 32'd0);
            check_val({tag, ".oe_n"}, 32'(bus.sram_oe_n), wr ? 32'd1 : 32'd0);
            check_val({tag, ".we_n"}, 32'(bus.sram_we_n), (wr && i < stalls) ? 32'd0 : 32'd1);
            check_val({tag, ".be_n"}, 32'(bus.sram_be_n), 32'(be_exp));
            if (i == stalls && !wr) begin
                check_val({tag, ".data"}, is_fetch ? bus.codebus : bus.inbus, data_exp);
            end
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.sram_din = 32'hA0000005;
        bus.io_rdata = 32'h12345678;
        drive(24'h000100, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        // Reset holds every strobe inactive even with an SRAM fetch presented
        check_val("rst.memwait", 32'(bus.memwait), 32'd0);
        check_val("rst.ce_n", 32'(bus.sram_ce_n), 32'd1);
        check_val("rst.oe_n", 32'(bus.sram_oe_n), 32'd1);
        check_val("rst.we_n", 32'(bus.sram_we_n), 32'd1);
        check_val("rst.be_n", 32'(bus.sram_be_n), 32'hF);
        check_val("rst.io_rd", 32'(bus.io_rd), 32'd0);
        drive_idle();
        rst = 1'b0;
        next_cycle();

        // SRAM fetch: memwait 1,1,0 and codebus valid in the third cycle
        drive(24'h000100, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_val("fetch.sram_a", 32'(bus.sram_a), 32'h000040);
        run_sram("fetch", 2, 1'b0, 4'h0, 32'hA0000005, 1'b1);

        // Same PC again: full wait without the buffer, immediate hit with it
`ifdef RISC5_MEM_FETCH_BUF_EN
        bus.sram_din = 32'h0BAD0BAD;
        @(negedge clk);
        check_val("refetch.memwait", 32'(bus.memwait), 32'd0);
        check_val("refetch.ce_n", 32'(bus.sram_ce_n), 32'd1);
        check_val("refetch.codebus", bus.codebus, 32'hA0000005);
        next_cycle();
`else
        run_sram("refetch", 2, 1'b0, 4'h0, 32'hA0000005, 1'b1);
`endif

        // SB to 0x000203: lane 3 only
        drive(24'h000203, 1'b0, 1'b1, 1'b1, 32'hAA000000);
        #1;
        check_val("sb.sram_a", 32'(bus.sram_a), 32'h000080);
        check_val("sb.dout", bus.sram_dout, 32'hAA000000);
        run_sram("sb", 2, 1'b1, 4'b0111, 32'h0, 1'b0);

        // SB to lane 1
        drive(24'h000201, 1'b0, 1'b1, 1'b1, 32'h0000BB00);
        run_sram("sb1", 2, 1'b1, 4'b1101, 32'h0, 1'b0);

        // SW to the fetched word, then that fetch must stall again
        drive(24'h000100, 1'b0, 1'b1, 1'b0, 32'h11223344);
        run_sram("sw", 2, 1'b1, 4'h0, 32'h0, 1'b0);
        bus.sram_din = 32'h11223344;
        drive(24'h000100, 1'b0, 1'b0, 1'b0, 32'h0);
        run_sram("fetch_after_sw", 2, 1'b0, 4'h0, 32'h11223344, 1'b1);

        // SRAM load
        bus.sram_din = 32'hDEADBEEF;
        drive(24'h000010, 1'b1, 1'b0, 1'b0, 32'h0);
        run_sram("ldr", 2, 1'b0, 4'h0, 32'hDEADBEEF, 1'b0);

        // rd and wr together behave as a write
        drive(24'h000040, 1'b1, 1'b1, 1'b0, 32'h5A5A5A5A);
        run_sram("rdwr", 2, 1'b1, 4'h0, 32'h0, 1'b0);

        // I/O load: zero wait, one-cycle strobe
        drive(24'hFFFFC4, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_val("io_ld.memwait", 32'(bus.memwait), 32'd0);
        check_val("io_ld.io_rd", 32'(bus.io_rd), 32'd1);
        check_val("io_ld.io_wr", 32'(bus.io_wr), 32'd0);
        check_val("io_ld.io_adr", 32'(bus.io_adr), 32'd1);
        check_val("io_ld.inbus", bus.inbus, 32'h12345678);
        check_val("io_ld.ce_n", 32'(bus.sram_ce_n), 32'd1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        check_val("io_ld.io_rd_drop", 32'(bus.io_rd), 32'd0);
        next_cycle();

        // I/O store
        drive(24'hFFFFC0, 1'b0, 1'b1, 1'b0, 32'h00000077);
        @(negedge clk);
        check_val("io_st.io_wr", 32'(bus.io_wr), 32'd1);
        check_val("io_st.io_rd", 32'(bus.io_rd), 32'd0);
        check_val("io_st.io_adr", 32'(bus.io_adr), 32'd0);
        check_val("io_st.memwait", 32'(bus.memwait), 32'd0);
        check_val("io_st.we_n", 32'(bus.sram_we_n), 32'd1);
        next_cycle();

        // Boot-ROM fetch: no SRAM cycle
        drive(24'hFFE000, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_val("rom.memwait", 32'(bus.memwait), 32'd0);
        check_val("rom.ce_n", 32'(bus.sram_ce_n), 32'd1);
        check_val("rom.oe_n", 32'(bus.sram_oe_n), 32'd1);
        check_val("rom.we_n", 32'(bus.sram_we_n), 32'd1);
        next_cycle();

        // Reset asserted in WAIT (cnt=1) during a write
        drive(24'h000300, 1'b0, 1'b1, 1'b0, 32'h55555555);
        @(negedge clk);
        check_val("rstw.c1_memwait", 32'(bus.memwait), 32'd1);
        next_cycle();
        @(negedge clk);
        check_val("rstw.c2_we_n", 32'(bus.sram_we_n), 32'd0);
        rst = 1'b1;
        #1;
        check_val("rstw.memwait", 32'(bus.memwait), 32'd0);
        check_val("rstw.we_n", 32'(bus.sram_we_n), 32'd1);
        check_val("rstw.oe_n", 32'(bus.sram_oe_n), 32'd1);
        check_val("rstw.ce_n", 32'(bus.sram_ce_n), 32'd1);
        drive_idle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        // A fresh read must see the full IDLE->WAIT sequence
        bus.sram_din = 32'hCAFEF00D;
        drive(24'h000010, 1'b1, 1'b0, 1'b0, 32'h0);
        run_sram("post_rst", 2, 1'b0, 4'h0, 32'hCAFEF00D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
